// File: rtl/threshold_monitor.sv
// threshold_monitor: per-channel debounced signed threshold comparator.
// Each channel owns a writable threshold. A BELOW/RISING/ABOVE/FALLING FSM
// needs PERSIST consecutive qualifying samples before it changes its flag.
// A sticky bit latches every rising edge of a flag until it is cleared.
// Optional feature macro: THRMON_HYST_EN. When it is defined, a channel is
// released only when in_data <= thr - HYST. When it is not defined, a channel
// is released when in_data <= thr, and no hysteresis logic is built.
module threshold_monitor #(
  parameter int DATA_W  = 32,
  parameter int NUM_THR = 4,
  parameter int PERSIST = 3,
  parameter int HYST    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     thr_wr_en,
  input  logic [3:0]               thr_wr_idx,
  input  logic signed [DATA_W-1:0] thr_wr_data,
  input  logic [NUM_THR-1:0]       sticky_clr,
  output logic [NUM_THR-1:0]       over,
  output logic                     over_valid,
  output logic [NUM_THR-1:0]       sticky_over
);

  // Stop elaboration on a parameter set that the logic cannot support
  if (NUM_THR < 1 || NUM_THR > 16 || PERSIST < 1 || PERSIST > 255 || HYST < 0) begin : g_param_check
    $error("threshold_monitor: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_BELOW   = 2'd0,
    ST_RISING  = 2'd1,
    ST_ABOVE   = 2'd2,
    ST_FALLING = 2'd3
  } state_t;

  localparam logic [7:0] PERSIST_C = 8'(PERSIST);

  state_t                     state_q [NUM_THR];
  state_t                     state_d [NUM_THR];
  logic [7:0]                 cnt_q   [NUM_THR];
  logic [7:0]                 cnt_d   [NUM_THR];
  logic signed [DATA_W-1:0]   thr_q   [NUM_THR];
  logic signed [DATA_W-1:0]   thr_d   [NUM_THR];
  logic [NUM_THR-1:0]         over_q;
  logic [NUM_THR-1:0]         over_d;
  logic                       over_valid_q;
  logic                       over_valid_d;
  logic [NUM_THR-1:0]         sticky_q;
  logic [NUM_THR-1:0]         sticky_d;
  logic [NUM_THR-1:0]         above_vec;
  logic [NUM_THR-1:0]         rel_vec;

`ifdef THRMON_HYST_EN
  // The release level is formed one bit wider so thr - HYST cannot wrap
  localparam logic signed [DATA_W:0] HYST_EXT = (DATA_W + 1)'(HYST);
  logic signed [DATA_W:0]     in_ext;
  logic signed [DATA_W:0]     thr_rel [NUM_THR];

  // Release compares the sample against the threshold lowered by HYST
  always_comb begin
    in_ext  = {in_data[DATA_W-1], in_data};
    rel_vec = '0;
    for (int i = 0; i < NUM_THR; i++) begin
      thr_rel[i] = $signed({thr_q[i][DATA_W-1], thr_q[i]}) - HYST_EXT;
      rel_vec[i] = (in_ext <= thr_rel[i]);
    end
  end
`else
  // Without hysteresis, release is simply "not above"
  always_comb begin
    rel_vec = '0;
    for (int i = 0; i < NUM_THR; i++) begin
      rel_vec[i] = (in_data <= thr_q[i]);
    end
  end
`endif

  // Strict signed "above" test against the threshold held before any write this cycle
  always_comb begin
    above_vec = '0;
    for (int i = 0; i < NUM_THR; i++) begin
      above_vec[i] = (in_data > thr_q[i]);
    end
  end

  // Per-channel debounce FSM next state; only a valid sample moves it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NUM_THR; i++) begin
      if (in_valid) begin
        case (state_q[i])
          ST_BELOW: begin
            if (above_vec[i]) begin
              if (PERSIST_C == 8'd1) begin
                state_d[i] = ST_ABOVE;
                cnt_d[i]   = 8'd0;
              end else begin
                state_d[i] = ST_RISING;
                cnt_d[i]   = 8'd1;
              end
            end else begin
              cnt_d[i] = 8'd0;
            end
          end
          ST_RISING: begin
            if (above_vec[i]) begin
              if ((cnt_q[i] + 8'd1) == PERSIST_C) begin
                state_d[i] = ST_ABOVE;
                cnt_d[i]   = 8'd0;
              end else begin
                cnt_d[i] = (cnt_q[i] == 8'hFF) ? cnt_q[i] : cnt_q[i] + 8'd1;
              end
            end else begin
              state_d[i] = ST_BELOW;
              cnt_d[i]   = 8'd0;
            end
          end
          ST_ABOVE: begin
            if (rel_vec[i]) begin
              if (PERSIST_C == 8'd1) begin
                state_d[i] = ST_BELOW;
                cnt_d[i]   = 8'd0;
              end else begin
                state_d[i] = ST_FALLING;
                cnt_d[i]   = 8'd1;
              end
            end else begin
              cnt_d[i] = 8'd0;
            end
          end
          ST_FALLING: begin
            if (rel_vec[i]) begin
              if ((cnt_q[i] + 8'd1) == PERSIST_C) begin
                state_d[i] = ST_BELOW;
                cnt_d[i]   = 8'd0;
              end else begin
                cnt_d[i] = (cnt_q[i] == 8'hFF) ? cnt_q[i] : cnt_q[i] + 8'd1;
              end
            end else begin
              state_d[i] = ST_ABOVE;
              cnt_d[i]   = 8'd0;
            end
          end
          default: begin
            state_d[i] = ST_BELOW;
            cnt_d[i]   = 8'd0;
          end
        endcase
      end
    end
  end

  // Threshold writes; an index with no matching channel falls through untouched
  always_comb begin
    thr_d = thr_q;
    for (int i = 0; i < NUM_THR; i++) begin
      if (thr_wr_en && (thr_wr_idx == 4'(i))) begin
        thr_d[i] = thr_wr_data;
      end
    end
  end

  // Output flags follow the next state; sticky set on a flag rise beats a clear
  always_comb begin
    over_d = '0;
    for (int i = 0; i < NUM_THR; i++) begin
      over_d[i] = (state_d[i] == ST_ABOVE) || (state_d[i] == ST_FALLING);
    end
    over_valid_d = in_valid;
    sticky_d     = (sticky_q & ~sticky_clr) | (over_d & ~over_q);
  end

  // State, thresholds and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_THR; i++) begin
        state_q[i] <= ST_BELOW;
        cnt_q[i]   <= 8'd0;
        thr_q[i]   <= DATA_W'(100 * (i + 1));
      end
      over_q       <= '0;
      over_valid_q <= 1'b0;
      sticky_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      thr_q        <= thr_d;
      over_q       <= over_d;
      over_valid_q <= over_valid_d;
      sticky_q     <= sticky_d;
    end
  end

  assign over        = over_q;
  assign over_valid  = over_valid_q;
  assign sticky_over = sticky_q;

endmodule
